// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: single-owner arbiter steering load/store queue requests onto one dcache ufp port
package dcache_port_arbiter_pkg;
   typedef struct packed {
      logic [31:0] ufp_addr;
      logic [3:0]  ufp_rmask;
      logic [3:0]  ufp_wmask;
      logic [31:0] ufp_wdata;
   } cache_interface_t;
endpackage

module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int STORE_BURST_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  cache_interface_t lq_req,
   output logic             lq_resp,
   output logic [31:0]      lq_rdata,
   input  cache_interface_t sq_req,
   output logic             sq_resp,
   output cache_interface_t cache_req,
   input  logic             cache_resp,
   input  logic [31:0]      cache_rdata,
   output logic             busy,
   output logic             owner_is_store
);
   localparam logic [3:0] BURST_MAX = 4'(STORE_BURST_MAX);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t     state;
   logic       owner;
   logic [3:0] burst_cnt;
   logic       lq_v, sq_v, win, issue, pick_st, done;
   logic       unused_bits;
   // arbitration and response steering; rst gates the outputs so they drop to 0 without a clock edge
   always_comb begin
      lq_v           = |lq_req.ufp_rmask;
      sq_v           = |sq_req.ufp_wmask;
      done           = rst && state == BUSY && cache_resp;
      win            = rst && (state == IDLE || cache_resp);
      issue          = win && (lq_v || sq_v);
      pick_st        = sq_v && (!lq_v || burst_cnt < BURST_MAX);
      cache_req      = !issue ? '0 :
                       pick_st ? cache_interface_t'{sq_req.ufp_addr, 4'b0, sq_req.ufp_wmask, sq_req.ufp_wdata}
                               : cache_interface_t'{lq_req.ufp_addr, lq_req.ufp_rmask, 4'b0, 32'b0};
      lq_resp        = done && !owner;
      sq_resp        = done && owner;
      lq_rdata       = lq_resp ? cache_rdata : '0;
      busy           = state == BUSY;
      owner_is_store = owner && busy;
      unused_bits    = ^{lq_req.ufp_wmask, lq_req.ufp_wdata, sq_req.ufp_rmask};
   end
   // state, owner and store-burst counter advance only in the issue window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         burst_cnt <= '0;
      end else if (win) begin
         state     <= issue ? BUSY : IDLE;
         owner     <= issue ? pick_st : owner;
         burst_cnt <= (lq_v && pick_st) ? burst_cnt + 4'd1 : '0;
      end
   end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed and randomized checks against a behavioural port model
module tb_dcache_port_arbiter;
   import dcache_port_arbiter_pkg::*;
   localparam int BMAX = 4;
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   cache_interface_t lq_req, sq_req, cache_req;
   logic             lq_resp, sq_resp, cache_resp, busy, owner_is_store;
   logic [31:0]      lq_rdata, cache_rdata;
   int               checks = 0, errors = 0;
   bit               m_busy, m_owner;
   int               m_cnt, last_g, lat;
   bit               rec;
   string            seq;
   cache_interface_t lreq, sreq;
   bit               lp, sp, r;

   dcache_port_arbiter #(.STORE_BURST_MAX(BMAX)) dut (
      .clk(clk), .rst(rst), .lq_req(lq_req), .lq_resp(lq_resp), .lq_rdata(lq_rdata),
      .sq_req(sq_req), .sq_resp(sq_resp), .cache_req(cache_req), .cache_resp(cache_resp),
      .cache_rdata(cache_rdata), .busy(busy), .owner_is_store(owner_is_store)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic cache_interface_t ld(input logic [31:0] a, input logic [3:0] m);
      cache_interface_t c = '0;
      c.ufp_addr  = a;
      c.ufp_rmask = m;
      return c;
   endfunction

   function automatic cache_interface_t st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      cache_interface_t c = '0;
      c.ufp_addr  = a;
      c.ufp_wmask = m;
      c.ufp_wdata = d;
      return c;
   endfunction

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_cnt   = 0;
   endtask

   task automatic cyc(input cache_interface_t l, input cache_interface_t s, input logic rs, input logic [31:0] d);
      bit lv, sv, w, gs, gnt, lr, sr;
      cache_interface_t er;
      lq_req = l; sq_req = s; cache_resp = rs; cache_rdata = d;
      #1;
      lv = l.ufp_rmask != 0;
      sv = s.ufp_wmask != 0;
      lr = m_busy && rs && !m_owner;
      sr = m_busy && rs && m_owner;
      chk("busy", busy, m_busy);
      chk("owner_is_store", owner_is_store, m_busy && m_owner);
      chk("lq_resp", lq_resp, lr);
      chk("sq_resp", sq_resp, sr);
      chk("lq_rdata", lq_rdata, lr ? d : 32'h0);
      w   = !m_busy || rs;
      gnt = w && (lv || sv);
      gs  = sv && (!lv || m_cnt < BMAX);
      er  = '0;
      if (gnt) er = gs ? st(s.ufp_addr, s.ufp_wmask, s.ufp_wdata) : ld(l.ufp_addr, l.ufp_rmask);
      chk("cache_req", cache_req, er);
      if (rec) seq = {seq, cache_req.ufp_wmask != 0 ? "S" : cache_req.ufp_rmask != 0 ? "L" : "-"};
      last_g = !gnt ? 0 : gs ? 2 : 1;
      if (w) begin
         m_busy = gnt;
         if (gnt) m_owner = gs;
         m_cnt = (gnt && gs && lv) ? ((m_cnt + 1 > BMAX) ? BMAX : m_cnt + 1) : 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      cache_interface_t la, lb, sa, z;
      z = '0;
      model_reset();
      rec = 0;
      lat = 0;
      la = ld(32'h1000, 4'b1111);
      lb = ld(32'h1008, 4'b1111);
      sa = st(32'h2004, 4'b0011, 32'h0000ABCD);
      // held in reset with both requests valid and a response strobe present
      lq_req = la; sq_req = sa; cache_resp = 1'b1; cache_rdata = 32'hFFFF_FFFF;
      #1;
      chk("rst_cache_req", cache_req, 72'h0);
      chk("rst_lq_resp", lq_resp, 1'b0);
      chk("rst_sq_resp", sq_resp, 1'b0);
      chk("rst_lq_rdata", lq_rdata, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner_is_store, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      // single load, response three cycles after issue
      cyc(la, z, 0, 0);
      cyc(la, z, 0, 0);
      cyc(la, z, 0, 0);
      cyc(z, z, 1, 32'hDEADBEEF);
      cyc(z, z, 0, 0);
      // single store
      cyc(z, sa, 0, 0);
      cyc(z, sa, 0, 0);
      cyc(z, z, 1, 32'h12345678);
      cyc(z, z, 0, 0);
      // back-to-back loads: B issued in A's response cycle
      cyc(la, z, 0, 0);
      cyc(la, z, 0, 0);
      cyc(lb, z, 1, 32'h11111111);
      cyc(lb, z, 0, 0);
      cyc(z, z, 1, 32'h22222222);
      cyc(z, z, 0, 0);
      // starvation: both sides continuously valid, every cycle a response
      seq = "";
      rec = 1;
      for (int i = 0; i < 10; i++) cyc(la, sa, i != 0, 32'hA0 + i);
      rec = 0;
      checks++;
      assert (seq == "SSSSLSSSSL") else begin
         errors++;
         $error("FAIL grant_order: observed %s expected SSSSLSSSSL", seq);
      end
      cyc(z, z, 1, 32'h5);
      cyc(z, z, 0, 0);
      // spurious response in IDLE, alone and together with a new load
      cyc(z, z, 1, 32'hBAD0);
      cyc(la, z, 1, 32'hBAD1);
      // asynchronous reset while BUSY with a response strobe present
      #2;
      cache_resp = 1'b1;
      rst = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_lq_resp", lq_resp, 1'b0);
      chk("arst_sq_resp", sq_resp, 1'b0);
      chk("arst_lq_rdata", lq_rdata, 32'h0);
      chk("arst_cache_req", cache_req, 72'h0);
      chk("arst_owner", owner_is_store, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(z, z, 1, 32'hBAD2);
      cyc(z, z, 0, 0);
      // randomized traffic with a cache of random latency
      lp = 0; sp = 0; lreq = z; sreq = z;
      for (int i = 0; i < 400; i++) begin
         r = 0;
         if (m_busy) begin
            lat--;
            r = lat == 0;
         end else r = ($urandom % 6) == 0;
         if (r && m_busy && !m_owner) lp = 0;
         if (r && m_busy && m_owner) sp = 0;
         if (!lp && ($urandom % 2) == 1) begin
            lp = 1;
            lreq = ld($urandom, 4'($urandom_range(1, 15)));
            lreq.ufp_wmask = 4'($urandom);
            lreq.ufp_wdata = $urandom;
         end
         if (!sp && ($urandom % 2) == 1) begin
            sp = 1;
            sreq = st($urandom, 4'($urandom_range(1, 15)), $urandom);
            sreq.ufp_rmask = 4'($urandom);
         end
         cyc(lp ? lreq : z, sp ? sreq : z, r, $urandom);
         if (last_g != 0) lat = $urandom_range(1, 3);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
